// File: rtl/sf_pkg.sv
// Shared encodings for the player action path: FSM state codes, controller bit positions
// and screen geometry used by the renderer side.
package sf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WALK      = 3'd1,
    ST_CROUCH    = 3'd2,
    ST_JUMP_UP   = 3'd3,
    ST_JUMP_DOWN = 3'd4,
    ST_ATTACK    = 3'd5,
    ST_COOLDOWN  = 3'd6,
    ST_SHIELD    = 3'd7
  } state_t;

  localparam int CTRL_LEFT   = 1;
  localparam int CTRL_RIGHT  = 2;
  localparam int CTRL_UP     = 3;
  localparam int CTRL_DOWN   = 4;
  localparam int CTRL_ATTACK = 5;
  localparam int CTRL_SHIELD = 6;

  localparam int H_VISIBLE = 640;
  localparam int V_VISIBLE = 480;
  localparam int SPRITE_W  = 32;

endpackage

// File: rtl/tick_gen.sv
// Free-running divider: one-clk registered pulse every TICK_MAX clocks, first pulse
// TICK_MAX clocks after reset is released.
module tick_gen #(
  parameter int TICK_MAX = 714285
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int            CW   = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_MAX - 1);

  logic [CW-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      tick  <= 1'b0;
    end else begin
      tick  <= (count == LAST);
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/player_action_ctrl.sv
// Per-player action sequencer: controller vector in, registered position and action state out.
// Optional feature macro: PLAYER_DOUBLE_JUMP_EN (one extra jump per airtime on an up edge).
module player_action_ctrl
  import sf_pkg::*;
#(
  parameter int TICK_MAX       = 714285,
  parameter int X_INIT         = 300,
  parameter int Y_GROUND       = 300,
  parameter int X_MIN          = 0,
  parameter int X_MAX          = 608,
  parameter int JUMP_HEIGHT    = 64,
  parameter int JUMP_STEP      = 2,
  parameter int ATTACK_TICKS   = 12,
  parameter int COOLDOWN_TICKS = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] ctrl_in,
  output logic [9:0] player_x,
  output logic [9:0] player_y,
  output logic [2:0] state,
  output logic       attack_active,
  output logic       shield_active,
  output logic       facing,
  output logic       tick
);

  localparam int         CNT_MAX = (ATTACK_TICKS > COOLDOWN_TICKS) ? ATTACK_TICKS : COOLDOWN_TICKS;
  localparam int         CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [9:0] APEX    = 10'(Y_GROUND - JUMP_HEIGHT);

  logic left, right, up, down, attack, shield;
  logic unused_bit0;

  assign left        = ctrl_in[CTRL_LEFT];
  assign right       = ctrl_in[CTRL_RIGHT];
  assign up          = ctrl_in[CTRL_UP];
  assign down        = ctrl_in[CTRL_DOWN];
  assign attack      = ctrl_in[CTRL_ATTACK];
  assign shield      = ctrl_in[CTRL_SHIELD];
  assign unused_bit0 = ctrl_in[0];

  tick_gen #(.TICK_MAX(TICK_MAX)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  state_t           state_q, state_d;
  logic [9:0]       x_q, x_d, y_q, y_d;
  logic             facing_q, facing_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             armed_q, armed_d;
  logic [9:0]       apex;

  // One step left/right in signed 11-bit space, clamped so x never wraps below zero.
  function automatic logic [9:0] step_x(input logic [9:0] x, input logic dec, input logic inc);
    logic signed [10:0] nx;
    nx = $signed({1'b0, x});
    if (dec && !inc)      nx = nx - 11'sd1;
    else if (inc && !dec) nx = nx + 11'sd1;
    if (nx < $signed(11'(X_MIN)))      nx = $signed(11'(X_MIN));
    else if (nx > $signed(11'(X_MAX))) nx = $signed(11'(X_MAX));
    return 10'(nx);
  endfunction

  logic signed [10:0] y_rise, y_fall;
  assign y_rise = $signed({1'b0, y_q}) - $signed(11'(JUMP_STEP));
  assign y_fall = $signed({1'b0, y_q}) + $signed(11'(JUMP_STEP));

`ifdef PLAYER_DOUBLE_JUMP_EN
  logic             up_prev_q, dj_used_q, dj_used_d;
  logic [9:0]       apex_q, apex_d;
  logic             up_edge;
  logic signed [10:0] dj_apex;

  assign apex    = apex_q;
  assign up_edge = up && !up_prev_q && !dj_used_q;
  assign dj_apex = $signed({1'b0, y_q}) - $signed(11'(JUMP_HEIGHT));

  always_ff @(posedge clk) begin
    if (rst) begin
      up_prev_q <= 1'b0;
      dj_used_q <= 1'b0;
      apex_q    <= APEX;
    end else if (tick) begin
      up_prev_q <= up;
      dj_used_q <= dj_used_d;
      apex_q    <= apex_d;
    end
  end
`else
  assign apex = APEX;
`endif

  // NOTE: every variable gets its hold value first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    facing_d = facing_q;
    cnt_d    = cnt_q;
    armed_d  = armed_q;
`ifdef PLAYER_DOUBLE_JUMP_EN
    apex_d    = apex_q;
    dj_used_d = dj_used_q;
`endif
    if (tick) begin
      if (!attack) armed_d = 1'b1;
      unique case (state_q)
        ST_IDLE, ST_WALK, ST_CROUCH: begin
          if (shield) begin
            state_d = ST_SHIELD;
          end else if (attack && armed_q) begin
            state_d = ST_ATTACK;
            cnt_d   = CNT_W'(ATTACK_TICKS);
            armed_d = 1'b0;
          end else if (up) begin
            state_d = ST_JUMP_UP;
          end else if (down) begin
            state_d = ST_CROUCH;
          end else if (left ^ right) begin
            state_d  = ST_WALK;
            x_d      = step_x(x_q, left, right);
            facing_d = left;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_JUMP_UP, ST_JUMP_DOWN: begin
          x_d = step_x(x_q, left, right);
`ifdef PLAYER_DOUBLE_JUMP_EN
          if (up_edge) begin
            state_d   = ST_JUMP_UP;
            apex_d    = (dj_apex < 11'sd0) ? 10'd0 : 10'(dj_apex);
            dj_used_d = 1'b1;
          end else
`endif
          if (state_q == ST_JUMP_UP) begin
            if (y_rise <= $signed({1'b0, apex})) begin
              y_d     = apex;
              state_d = ST_JUMP_DOWN;
            end else begin
              y_d = 10'(y_rise);
            end
          end else begin
            if (y_fall >= $signed(11'(Y_GROUND))) begin
              y_d     = 10'(Y_GROUND);
              state_d = ST_IDLE;
`ifdef PLAYER_DOUBLE_JUMP_EN
              apex_d    = APEX;
              dj_used_d = 1'b0;
`endif
            end else begin
              y_d = 10'(y_fall);
            end
          end
        end
        ST_ATTACK: begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_COOLDOWN;
            cnt_d   = CNT_W'(COOLDOWN_TICKS);
          end
        end
        ST_COOLDOWN: begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_d = ST_IDLE;
        end
        ST_SHIELD: begin
          if (!shield) state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      x_q      <= 10'(X_INIT);
      y_q      <= 10'(Y_GROUND);
      facing_q <= 1'b0;
      cnt_q    <= '0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      facing_q <= facing_d;
      cnt_q    <= cnt_d;
      armed_q  <= armed_d;
    end
  end

  assign player_x      = x_q;
  assign player_y      = y_q;
  assign state         = state_q;
  assign facing        = facing_q;
  assign attack_active = (state_q == ST_ATTACK);
  assign shield_active = (state_q == ST_SHIELD);

endmodule

// File: tb/tb_player_action_ctrl.sv
// Directed bench for player_action_ctrl with a 4-clock movement tick and default geometry.
module tb_player_action_ctrl;

  localparam int TM = 4;
  localparam logic [6:0] C_L = 7'h02, C_R = 7'h04, C_U = 7'h08, C_D = 7'h10,
                         C_A = 7'h20, C_S = 7'h40;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] ctrl_in;
  logic [9:0] player_x, player_y;
  logic [2:0] state;
  logic       attack_active, shield_active, facing, tick;

  always #5 clk = ~clk;

  player_action_ctrl #(.TICK_MAX(TM)) dut (
    .clk           (clk),
    .rst           (rst),
    .ctrl_in       (ctrl_in),
    .player_x      (player_x),
    .player_y      (player_y),
    .state         (state),
    .attack_active (attack_active),
    .shield_active (shield_active),
    .facing        (facing),
    .tick          (tick)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Walk to the clock after the next tick pulse, i.e. where its update becomes visible.
  task automatic next_tick();
    int n;
    n = 0;
    while (tick !== 1'b1 && n < 3 * TM) begin
      @(posedge clk); #1;
      n++;
    end
    check("tick_seen", int'(tick === 1'b1), 1);
    @(posedge clk); #1;
  endtask

  // Counts clocks from reset release until the first tick pulse is visible.
  task automatic measure_first_tick(input string tag);
    int first;
    first = 0;
    for (int i = 1; i <= 3 * TM; i++) begin
      @(posedge clk); #1;
      if (tick === 1'b1) begin
        first = i;
        break;
      end
    end
    check(tag, first, TM);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_x"}, player_x, 300);
    check({tag, "_y"}, player_y, 300);
    check({tag, "_state"}, state, 0);
    check({tag, "_attack"}, attack_active, 0);
    check({tag, "_shield"}, shield_active, 0);
    check({tag, "_tick"}, tick, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int ex, ey, es, att_cnt;
    rst     = 1'b1;
    ctrl_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    check("reset_facing", facing, 0);
    rst = 1'b0;
    measure_first_tick("first_tick");
    next_tick();
    check("tick_width", tick, 0);
    check("idle_state", state, 0);

    // Walk left into the clamp, then both directions together.
    ctrl_in = C_L;
    ex = 300;
    for (int i = 1; i <= 310; i++) begin
      next_tick();
      ex = (ex > 0) ? ex - 1 : 0;
      check("walk_left_x", player_x, ex);
    end
    check("walk_left_facing", facing, 1);
    check("walk_left_state", state, 1);
    ctrl_in = C_L | C_R;
    next_tick();
    check("both_dirs_state", state, 0);
    check("both_dirs_x", player_x, 0);

    // Walk right into the upper clamp.
    ctrl_in = C_R;
    for (int i = 1; i <= 612; i++) begin
      next_tick();
      ex = (ex < 608) ? ex + 1 : 608;
      check("walk_right_x", player_x, ex);
    end
    check("walk_right_facing", facing, 0);
    check("walk_right_state", state, 1);

    // Down beats left: crouch freezes x and facing.
    ctrl_in = C_D | C_L;
    next_tick();
    check("crouch_state", state, 2);
    check("crouch_x", player_x, 608);
    check("crouch_facing", facing, 0);

    // Single jump, attack pressed mid-air.
    ctrl_in = C_U;
    next_tick();
    check("jump_start_state", state, 3);
    check("jump_start_y", player_y, 300);
    for (int k = 1; k <= 64; k++) begin
      ctrl_in = (k >= 10 && k <= 20) ? C_A : 7'h00;
      next_tick();
      ey = (k <= 32) ? 300 - 2 * k : 236 + 2 * (k - 32);
      es = (k < 32) ? 3 : (k < 64) ? 4 : 0;
      check("jump_y", player_y, ey);
      check("jump_state", state, es);
      check("jump_no_attack", attack_active, 0);
    end

    // Attack held: 12 ticks attack, 20 cooldown, then idle without retrigger.
    ctrl_in = C_A;
    att_cnt = 0;
    for (int j = 1; j <= 40; j++) begin
      next_tick();
      es = (j <= 12) ? 5 : (j <= 32) ? 6 : 0;
      check("attack_state", state, es);
      if (attack_active === 1'b1) att_cnt++;
    end
    check("attack_ticks", att_cnt, 12);
    ctrl_in = '0;
    next_tick();
    check("attack_release_state", state, 0);
    ctrl_in = C_A;
    next_tick();
    check("attack_again_state", state, 5);
    check("attack_again_active", attack_active, 1);

    // Reset in the middle of an attack.
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_values("rst_mid_attack");
    rst = 1'b0;
    ctrl_in = C_S | C_A | C_U;
    measure_first_tick("first_tick_after_attack_rst");

    // Shield has top priority; release returns to idle one tick later.
    next_tick();
    check("shield_state", state, 7);
    check("shield_active", shield_active, 1);
    next_tick();
    check("shield_hold_state", state, 7);
    ctrl_in = '0;
    next_tick();
    check("shield_release_state", state, 0);
    check("shield_release_active", shield_active, 0);

    // Reset in the middle of a jump at y = 250.
    ctrl_in = C_U;
    next_tick();
    ctrl_in = '0;
    repeat (25) next_tick();
    check("mid_jump_y", player_y, 250);
    check("mid_jump_state", state, 3);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_values("rst_mid_jump");
    rst = 1'b0;
    measure_first_tick("first_tick_after_jump_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
